// File: rtl/one_to_n_distributor.sv
// Steers packets from one flit stream to one of N registered output slots, locked per packet.
// Optional drop counter port/logic is built only when ONE_TO_N_DROP_CNT_EN is defined.
module one_to_n_distributor #(
    parameter int FLIT_SIZE  = 16,
    parameter int HEADER_LEN = 2,
    parameter logic [HEADER_LEN-1:0] BODY   = HEADER_LEN'(0),
    parameter logic [HEADER_LEN-1:0] TAIL   = HEADER_LEN'(1),
    parameter logic [HEADER_LEN-1:0] HEAD   = HEADER_LEN'(2),
    parameter logic [HEADER_LEN-1:0] SINGLE = HEADER_LEN'(3),
    parameter int N       = 3,
    parameter int SEL_W   = (N > 1) ? $clog2(N) : 1,
    parameter int DST_POS = FLIT_SIZE - HEADER_LEN - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [FLIT_SIZE-1:0]   in,
    input  logic                   in_valid,
    output logic                   in_avail,
    output logic [FLIT_SIZE*N-1:0] out,
    output logic [N-1:0]           out_valid,
    input  logic [N-1:0]           out_avail
`ifdef ONE_TO_N_DROP_CNT_EN
    ,
    output logic [15:0]            drop_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;

    state_t                 state_reg, state_next;
    logic [SEL_W-1:0]       lock_port_reg, lock_port_next;

    logic [FLIT_SIZE-1:0]   fifo_mem [2];
    logic                   wr_ptr_reg, rd_ptr_reg;
    logic [1:0]             count_reg;
    logic                   fifo_full, fifo_empty;
    logic                   push, pop;

    logic [FLIT_SIZE-1:0]   head;
    logic [HEADER_LEN-1:0]  head_type;
    logic [SEL_W-1:0]       dst;
    logic                   dst_ok;
    logic [N-1:0]           can_accept;
    logic                   dst_ready, lock_ready;
    logic                   move;
    logic [SEL_W-1:0]       tgt;
    logic [N-1:0]           load;

    assign fifo_full  = (count_reg == 2'd2);
    assign fifo_empty = (count_reg == 2'd0);
    assign in_avail   = ~fifo_full;
    // A full FIFO may still take a flit in the cycle its head leaves.
    assign push       = in_valid & (~fifo_full | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) wr_ptr_reg <= ~wr_ptr_reg;
            if (pop)  rd_ptr_reg <= ~rd_ptr_reg;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head      = fifo_mem[rd_ptr_reg];
    assign head_type = head[FLIT_SIZE-1 -: HEADER_LEN];
    assign dst       = head[DST_POS -: SEL_W];
    assign dst_ok    = ({1'b0, dst} < (SEL_W+1)'(N));

    // Loop compare avoids indexing can_accept with an out-of-range destination.
    always_comb begin
        dst_ready  = 1'b0;
        lock_ready = 1'b0;
        for (int p = 0; p < N; p++) begin
            if (dst == SEL_W'(p))           dst_ready  = can_accept[p];
            if (lock_port_reg == SEL_W'(p)) lock_ready = can_accept[p];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            lock_port_reg <= '0;
        end else begin
            state_reg     <= state_next;
            lock_port_reg <= lock_port_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        lock_port_next = lock_port_reg;
        pop            = 1'b0;
        move           = 1'b0;
        tgt            = lock_port_reg;
        if (!fifo_empty) begin
            case (state_reg)
                IDLE: begin
                    case (head_type)
                        HEAD: begin
                            if (dst_ok) begin
                                tgt = dst;
                                if (dst_ready) begin
                                    move           = 1'b1;
                                    pop            = 1'b1;
                                    lock_port_next = dst;
                                    state_next     = FWD;
                                end
                            end else begin
                                pop        = 1'b1;
                                state_next = DROP;
                            end
                        end
                        SINGLE: begin
                            tgt = dst;
                            if (!dst_ok) begin
                                pop = 1'b1;
                            end else if (dst_ready) begin
                                move = 1'b1;
                                pop  = 1'b1;
                            end
                        end
                        BODY, TAIL: pop = 1'b1;
                        default:    pop = 1'b1;
                    endcase
                end
                FWD: begin
                    if (lock_ready) begin
                        move = 1'b1;
                        pop  = 1'b1;
                        if (head_type == TAIL) state_next = IDLE;
                    end
                end
                DROP: begin
                    pop = 1'b1;
                    if (head_type == TAIL) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_slot
        logic [FLIT_SIZE-1:0] data_reg;
        logic                 valid_reg;

        assign load[gi]       = move & (tgt == SEL_W'(gi));
        assign can_accept[gi] = ~valid_reg | out_avail[gi];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                data_reg  <= '0;
                valid_reg <= 1'b0;
            end else if (load[gi]) begin
                data_reg  <= head;
                valid_reg <= 1'b1;
            end else if (out_avail[gi]) begin
                valid_reg <= 1'b0;
            end
        end

        assign out[FLIT_SIZE*gi +: FLIT_SIZE] = data_reg;
        assign out_valid[gi]                  = valid_reg;
    end

`ifdef ONE_TO_N_DROP_CNT_EN
    logic        drop_hit;
    logic [15:0] drop_cnt_reg;

    // Only a packet-opening flit with an unroutable destination counts as a drop.
    assign drop_hit = (state_reg == IDLE) & ~fifo_empty & ~dst_ok
                    & ((head_type == HEAD) | (head_type == SINGLE));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_cnt_reg <= 16'd0;
        end else if (drop_hit && (drop_cnt_reg != 16'hFFFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 16'd1;
        end
    end

    assign drop_cnt = drop_cnt_reg;
`endif

endmodule
